// File: rtl/sha_const_rom_reader.sv
// Read controller for the four 8K x 8 SHA-256 constant EEPROMs: drives shared
// CE/OE/A, inserts access wait states and assembles one 32-bit word per access.
module sha_const_rom_reader #(
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned H_BASE      = 0,
  parameter int unsigned K_BASE      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              sel_k,
  input  logic [5:0]        index,
  input  logic              load_h,
  output logic              ready,
  output logic              valid,
  output logic [31:0]       data,
  output logic [5:0]        word_idx,
  output logic              err,
  output logic [ADDR_W-1:0] a,
  output logic              ce,
  output logic              oe,
  output logic              we,
  input  logic [7:0]        io1,
  input  logic [7:0]        io2,
  input  logic [7:0]        io3,
  input  logic [7:0]        io4
);

  localparam int unsigned IDX_W   = 6;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned WAIT_W  = 4;
  localparam int unsigned BURST_W = 3;

  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(WAIT_CYCLES - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(7);
  localparam logic [IDX_W-1:0]   H_MAX_IDX  = IDX_W'(7);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_ACCESS  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  logic [2:0]         state_q,    state_d;
  logic [WAIT_W-1:0]  wait_q,     wait_d;
  logic               burst_q,    burst_d;
  logic [BURST_W-1:0] cnt_q,      cnt_d;
  logic [IDX_W-1:0]   idx_q,      idx_d;
  logic [ADDR_W-1:0]  a_q,        a_d;
  logic [DATA_W-1:0]  data_q,     data_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic               ce_q,       ce_d;
  logic               oe_q,       oe_d;
  logic               ready_q,    ready_d;
  logic               valid_q,    valid_d;
  logic               err_q,      err_d;
  logic               we_q;

  // Chip pin 0 carries the byte MSB, so each lane is bit-reversed into the word.
  function automatic logic [7:0] lane_byte(input logic [7:0] lane);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = lane[7-i];
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      burst_q    <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      a_q        <= '0;
      data_q     <= '0;
      word_idx_q <= '0;
      ce_q       <= 1'b1;
      oe_q       <= 1'b1;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      we_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      burst_q    <= burst_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      data_q     <= data_d;
      word_idx_q <= word_idx_d;
      ce_q       <= ce_d;
      oe_q       <= oe_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      we_q       <= 1'b1;
    end
  end

  // Next state and next registered outputs; strobes are derived from state_d
  // so that CE/OE/READY/VALID line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    burst_d    = burst_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    a_d        = a_q;
    data_d     = data_q;
    word_idx_d = word_idx_q;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_h) begin
          burst_d = 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
          a_d     = ADDR_W'(H_BASE);
          state_d = S_SETUP;
        end else if (req) begin
          if (sel_k) begin
            idx_d   = index;
            a_d     = ADDR_W'(K_BASE) + ADDR_W'(index);
            state_d = S_SETUP;
          end else if (index <= H_MAX_IDX) begin
            idx_d   = index;
            a_d     = ADDR_W'(H_BASE) + ADDR_W'(index);
            state_d = S_SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        wait_d  = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_CAPTURE: begin
        data_d     = {lane_byte(io1), lane_byte(io2), lane_byte(io3), lane_byte(io4)};
        word_idx_d = burst_q ? IDX_W'(cnt_q) : idx_q;
        state_d    = S_RECOVER;
      end
      S_RECOVER: begin
        if (burst_q && (cnt_q != BURST_LAST)) begin
          cnt_d   = cnt_q + BURST_W'(1);
          a_d     = ADDR_W'(H_BASE) + ADDR_W'(cnt_d);
          state_d = S_SETUP;
        end else begin
          burst_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        burst_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    ce_d    = !((state_d == S_SETUP) || (state_d == S_ACCESS) || (state_d == S_CAPTURE));
    oe_d    = !((state_d == S_ACCESS) || (state_d == S_CAPTURE));
    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_RECOVER);
  end

  assign ready    = ready_q;
  assign valid    = valid_q;
  assign data     = data_q;
  assign word_idx = word_idx_q;
  assign err      = err_q;
  assign a        = a_q;
  assign ce       = ce_q;
  assign oe       = oe_q;
  assign we       = we_q;

endmodule

// File: tb/tb_sha_const_rom_reader.sv
// Bench for sha_const_rom_reader: EEPROM model, vector table, burst/reset
// sequences, and a scoreboard that checks every VALID word.
`timescale 1ns/1ps
module tb_sha_const_rom_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, sel_k, load_h;
  logic [5:0]  index;
  logic        ready, valid, err, ce, oe, we;
  logic [31:0] data;
  logic [5:0]  word_idx;
  logic [12:0] a;
  logic [7:0]  io1, io2, io3, io4;

  always #5 clk = ~clk;

  sha_const_rom_reader #(.ADDR_W(13), .WAIT_CYCLES(4), .H_BASE(0), .K_BASE(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .sel_k(sel_k), .index(index),
    .load_h(load_h), .ready(ready), .valid(valid), .data(data),
    .word_idx(word_idx), .err(err), .a(a), .ce(ce), .oe(oe), .we(we),
    .io1(io1), .io2(io2), .io3(io3), .io4(io4)
  );

  typedef struct {
    logic [31:0] d;
    logic [5:0]  idx;
  } exp_t;

  typedef struct {
    string       nm;
    logic        sel;
    logic [5:0]  ix;
    logic        is_err;
    logic [31:0] d;
    logic [12:0] adr;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[8];
  logic [31:0] h_exp[8];
  int          n_checks = 0;
  int          n_fail   = 0;

  // EEPROM contents: H0..H7, K0, K1, K63 real; other cells a recognisable pattern
  function automatic logic [31:0] rom(input logic [12:0] ad);
    case (ad)
      13'd0:   return 32'h6a09e667;
      13'd1:   return 32'hbb67ae85;
      13'd2:   return 32'h3c6ef372;
      13'd3:   return 32'ha54ff53a;
      13'd4:   return 32'h510e527f;
      13'd5:   return 32'h9b05688c;
      13'd6:   return 32'h1f83d9ab;
      13'd7:   return 32'h5be0cd19;
      13'd8:   return 32'h428a2f98;
      13'd9:   return 32'h71374491;
      13'd71:  return 32'hc67178f2;
      default: return 32'hc0de0000 | 32'(ad);
    endcase
  endfunction

  function automatic logic [7:0] pin_order(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  logic [31:0] rom_word;
  always_comb rom_word = (!ce && !oe) ? rom(a) : 32'h0;
  assign io1 = pin_order(rom_word[31:24]);
  assign io2 = pin_order(rom_word[23:16]);
  assign io3 = pin_order(rom_word[15:8]);
  assign io4 = pin_order(rom_word[7:0]);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200 && !ready; i++) begin
      @(posedge clk); #1;
    end
    chk("wait_ready", 64'(ready), 64'd1);
  endtask

  // Single request; REQ/INDEX/SEL_K are scrambled while the access is in flight
  task automatic do_req(input vec_t v);
    int vfirst, vcount, celow, oelow, rfirst, errc;
    logic [12:0] a0;
    logic err0, rdy_all;
    wait_ready();
    req = 1'b1; sel_k = v.sel; index = v.ix;
    if (!v.is_err) sb.push_back('{v.d, v.ix});
    @(posedge clk); #1;
    vfirst = -1; vcount = 0; celow = 0; oelow = 0; rfirst = -1; errc = 0;
    rdy_all = 1'b1; a0 = a; err0 = err;
    for (int c = 0; c < 12; c++) begin
      if (valid) begin vcount++; if (vfirst < 0) vfirst = c; end
      if (!ce) celow++;
      if (!oe) oelow++;
      if (ready && rfirst < 0) rfirst = c;
      if (!ready) rdy_all = 1'b0;
      if (err) errc++;
      req   = (!v.is_err && c >= 1 && c <= 4) ? 1'(c % 2) : 1'b0;
      index = ~v.ix;
      sel_k = ~v.sel;
      @(posedge clk); #1;
    end
    if (v.is_err) begin
      chk({v.nm, "_err_pulse"}, 64'(err0), 64'd1);
      chk({v.nm, "_err_width"}, 64'(errc), 64'd1);
      chk({v.nm, "_ce_low_cycles"}, 64'(celow), 64'd0);
      chk({v.nm, "_valid_count"}, 64'(vcount), 64'd0);
      chk({v.nm, "_ready_held"}, 64'(rdy_all), 64'd1);
    end else begin
      chk({v.nm, "_addr"}, 64'(a0), 64'(v.adr));
      chk({v.nm, "_valid_cycle"}, 64'(vfirst), 64'd6);
      chk({v.nm, "_valid_count"}, 64'(vcount), 64'd1);
      chk({v.nm, "_ce_low_cycles"}, 64'(celow), 64'd6);
      chk({v.nm, "_oe_low_cycles"}, 64'(oelow), 64'd5);
      chk({v.nm, "_ready_cycle"}, 64'(rfirst), 64'd7);
      chk({v.nm, "_err_count"}, 64'(errc), 64'd0);
    end
    chk({v.nm, "_sb_drained"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        prev_oe_low;
    logic [12:0] prev_a;
    logic [63:0] mask, emask;
    int          rfirst, errc;
    exp_t        e;

    h_exp = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    vecs[0] = '{"h0",  1'b0, 6'd0,  1'b0, 32'h6a09e667, 13'd0};
    vecs[1] = '{"k0",  1'b1, 6'd0,  1'b0, 32'h428a2f98, 13'd8};
    vecs[2] = '{"k63", 1'b1, 6'd63, 1'b0, 32'hc67178f2, 13'd71};
    vecs[3] = '{"h9",  1'b0, 6'd9,  1'b1, 32'h0,        13'd0};
    vecs[4] = '{"h7",  1'b0, 6'd7,  1'b0, 32'h5be0cd19, 13'd7};
    vecs[5] = '{"k1",  1'b1, 6'd1,  1'b0, 32'h71374491, 13'd9};
    vecs[6] = '{"h8",  1'b0, 6'd8,  1'b1, 32'h0,        13'd0};
    vecs[7] = '{"k17", 1'b1, 6'd17, 1'b0, 32'hc0de0019, 13'd25};

    rst_n = 1'b0; req = 1'b0; sel_k = 1'b0; index = '0; load_h = 1'b0;
    prev_oe_low = 1'b0; prev_a = '0;

    // Bus monitor and scoreboard consumer
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          chk("we_high", 64'(we), 64'd1);
          if (!oe && prev_oe_low) chk("a_stable_oe_low", 64'(a), 64'(prev_a));
          if (valid) begin
            if (sb.size() == 0) begin
              chk("unexpected_valid", 64'(valid), 64'd0);
            end else begin
              e = sb.pop_front();
              chk("sb_data", 64'(data), 64'(e.d));
              chk("sb_word_idx", 64'(word_idx), 64'(e.idx));
            end
          end
          prev_a = a;
          prev_oe_low = !oe;
        end else begin
          prev_oe_low = 1'b0;
        end
      end
    join_none

    #12;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_word_idx", 64'(word_idx), 64'd0);
    chk("rst_a", 64'(a), 64'd0);
    chk("rst_ce", 64'(ce), 64'd1);
    chk("rst_oe", 64'(oe), 64'd1);
    chk("rst_we", 64'(we), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) do_req(vecs[i]);

    // H burst with a competing REQ held high
    wait_ready();
    load_h = 1'b1; req = 1'b1; sel_k = 1'b1; index = 6'd5;
    for (int k = 0; k < 8; k++) sb.push_back('{h_exp[k], 6'(k)});
    @(posedge clk); #1;
    load_h = 1'b0;
    mask = '0; rfirst = -1; errc = 0;
    for (int c = 0; c < 60; c++) begin
      if (valid) mask[c] = 1'b1;
      if (ready && rfirst < 0) rfirst = c;
      if (err) errc++;
      if (c == 50) req = 1'b0;
      @(posedge clk); #1;
    end
    emask = '0;
    for (int k = 0; k < 8; k++) emask[6 + 7*k] = 1'b1;
    chk("burst_valid_slots", mask, emask);
    chk("burst_ready_cycle", 64'(rfirst), 64'd56);
    chk("burst_err_count", 64'(errc), 64'd0);
    chk("burst_sb_drained", 64'(sb.size()), 64'd0);

    // Reset during ACCESS of burst word 3
    wait_ready();
    load_h = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back('{h_exp[k], 6'(k)});
    @(posedge clk); #1;
    load_h = 1'b0;
    for (int c = 0; c < 23; c++) begin
      @(posedge clk); #1;
    end
    chk("mid_reset_in_access", 64'({ce, oe}), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_ce", 64'(ce), 64'd1);
    chk("mid_reset_oe", 64'(oe), 64'd1);
    chk("mid_reset_valid", 64'(valid), 64'd0);
    chk("mid_reset_ready", 64'(ready), 64'd1);
    chk("mid_reset_sb", 64'(sb.size()), 64'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_req('{"post_reset_k1", 1'b1, 6'd1, 1'b0, 32'h71374491, 13'd9});

    repeat (10) @(posedge clk);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha_const_rom_reader.md
Name: sha_const_rom_reader

Overview:
- Read-side controller for the four 8K x 8 EEPROM chips that hold the SHA-256 constants.
- Chip 1 holds byte 3 (MSB) of each constant and chip 4 holds byte 0. Address 0..7 = H0..H7; address 8..71 = K0..K63.
- Drives the shared active-low chip controls and shared address bus, applies EEPROM access-time wait states, and assembles one 32-bit word.
- Serves single-word requests from the round datapath and an 8-word H-constant burst used at hash init.

Parameters:
- ADDR_W, 13, EEPROM address width.
- WAIT_CYCLES, 4, cycles OE is held low before sampling. Must satisfy WAIT_CYCLES x clock period >= 150 ns; 4 at 25 MHz. Legal range 1..15.
- H_BASE, 0, EEPROM address of H0.
- K_BASE, 8, EEPROM address of K0.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ  in  1  single-word request, sampled only when READY=1.
- SEL_K  in  1  1 = K table, 0 = H table.
- INDEX  in  6  constant index: K 0..63, H 0..7.
- LOAD_H  in  1  start 8-word H burst, sampled only when READY=1.
- READY  out  1  controller idle, can accept REQ or LOAD_H.
- VALID  out  1  one-cycle pulse: DATA/WORD_IDX updated.
- DATA  out  32  assembled constant = {IO1,IO2,IO3,IO4}.
- WORD_IDX  out  6  index of the word in DATA.
- ERR  out  1  one-cycle pulse: request rejected.
- A  out  ADDR_W  shared EEPROM address.
- CE  out  1  chip enable, active low, shared.
- OE  out  1  output enable, active low, shared.
- WE  out  1  write enable, active low. Tied high; the block never writes.
- IO1..IO4  in  8 each  EEPROM data lanes, chip 1..4. Lane bit 0 is MSB.

Behaviour:
- Reset (asynchronous, immediate, mid-operation included):
  - state=IDLE; CE=OE=WE=1; A=0.
  - READY=1, VALID=0, ERR=0, DATA=0, WORD_IDX=0, burst counter=0.
  - An in-flight access is abandoned; no VALID is produced for it.
- FSM states: IDLE, SETUP, ACCESS, CAPTURE, RECOVER.
- IDLE:
  - READY=1; CE=OE=1.
  - LOAD_H=1 wins over a simultaneous REQ. It sets burst mode, sets the counter to 0, sets A=H_BASE, and goes to SETUP.
  - REQ=1 with SEL_K=1 sets A=K_BASE+INDEX and goes to SETUP.
  - REQ=1 with SEL_K=0 and INDEX<=7 sets A=H_BASE+INDEX and goes to SETUP.
  - REQ=1 with SEL_K=0 and INDEX>7 pulses ERR for one cycle, stays in IDLE with READY=1, and makes no memory access.
- SETUP (1 cycle): CE=0, OE=1; A stable.
- ACCESS (WAIT_CYCLES cycles): CE=0, OE=0; wait counter runs.
- CAPTURE (1 cycle):
  - CE=0, OE=0.
  - Latches DATA={IO1,IO2,IO3,IO4} and WORD_IDX (INDEX, or the burst counter in burst mode).
  - VALID=1 during the following cycle.
- RECOVER (1 cycle):
  - CE=1, OE=1; VALID=1 in this cycle.
  - Single mode: go to IDLE.
  - Burst mode, counter<7: increment counter, set A=H_BASE+counter, go to SETUP.
  - Burst mode, counter=7: clear burst mode, go to IDLE.
- A changes only while CE=1 or in IDLE/RECOVER; it is never changed while OE=0.
- Latency:
  - REQ sampled at edge 0; VALID high in cycle WAIT_CYCLES+2, i.e. cycle 6 at the default.
  - READY returns high at cycle WAIT_CYCLES+3.
  - A burst produces 8 VALID pulses spaced WAIT_CYCLES+3 cycles apart. READY stays low for the whole burst.
- REQ/LOAD_H while READY=0 are ignored; there is no queueing and no ERR.
- DATA and WORD_IDX hold their value between captures.
- INDEX and SEL_K are captured at acceptance; later changes have no effect.
- Address arithmetic is ADDR_W bits unsigned; the valid range never wraps.

Test Plan:
- Reset, then REQ SEL_K=0 INDEX=0 -> VALID in cycle 6, DATA=0x6a09e667, WORD_IDX=0. CE low for exactly 6 cycles, OE low for exactly 5 cycles, WE high throughout.
- REQ SEL_K=1 INDEX=0, then INDEX=63 -> A=8 then 71; DATA=0x428a2f98, then 0xc67178f2.
- LOAD_H (with REQ asserted in the same cycle) -> 8 VALIDs, 7 cycles apart, with DATA in order: 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19. WORD_IDX 0..7; REQ ignored; READY low until after the last word.
- REQ SEL_K=0 INDEX=9 -> ERR pulse for 1 cycle; CE stays high; no VALID; READY stays 1.
- Assert RST_N low during ACCESS of burst word 3 -> CE/OE go high asynchronously and VALID=0. After release, a REQ K index 1 returns 0x71374491.
- Toggle REQ and INDEX during ACCESS -> no effect: the first request completes with its original data and one VALID.
